// File: rtl/adder_tree_pkg.sv
// Shared constants and the round-robin pick helper for the adder-tree scheduler.
package adder_tree_pkg;
    localparam int ADDER_WIDTH_DFLT = 48;
    localparam int NOPS             = 8;
    localparam int TREE_DEPTH       = 3;
    localparam int MAX_REQ          = 8;
    localparam int REQ_IDW          = 3;

    typedef struct packed {
        logic               found;
        logic [REQ_IDW-1:0] idx;
    } pick_t;

    // First valid requester at or after ptr, wrapping at nreq.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [REQ_IDW-1:0] ptr,
                                      input int                 nreq);
        pick_t              p;
        logic [REQ_IDW-1:0] idx;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = REQ_IDW'((int'(ptr) + k) % nreq);
            if (k < nreq && !p.found && valid[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/adder_tree_sched_if.sv
// Requester bundles in, tagged sums out; the scheduler is the slave side.
interface adder_tree_sched_if
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH = ADDER_WIDTH_DFLT,
    parameter int NREQ        = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]                  req_valid;
    logic [NREQ-1:0]                  req_ready;
    logic [NREQ*NOPS*ADDER_WIDTH-1:0] req_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [ADDER_WIDTH+2:0]           out_data;
    logic [IDW-1:0]                   out_id;
    logic [1:0]                       inflight;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, inflight
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, inflight
    );
endinterface

// File: rtl/adder_tree_pipe.sv
// 3-stage registered 8-operand adder tree with valid/tag sideband.
// Latency 3 enabled cycles; en=0 freezes every stage.
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int W   = ADDER_WIDTH_DFLT,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [IDW-1:0]    in_id,
    input  logic [NOPS*W-1:0] in_ops,
    output logic              out_valid,
    output logic [IDW-1:0]    out_id,
    output logic [W+2:0]      out_sum
);
    logic [W:0]     s1_sum_q [NOPS/2];
    logic [W:0]     s1_sum_d [NOPS/2];
    logic [W+1:0]   s2_sum_q [NOPS/4];
    logic [W+1:0]   s2_sum_d [NOPS/4];
    logic [W+2:0]   out_sum_q, out_sum_d;
    logic           s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, out_vld_q, out_vld_d;
    logic [IDW-1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d, out_id_q, out_id_d;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s2_vld_d  = s2_vld_q;
        out_vld_d = out_vld_q;
        s1_id_d   = s1_id_q;
        s2_id_d   = s2_id_q;
        out_id_d  = out_id_q;
        s1_sum_d  = s1_sum_q;
        s2_sum_d  = s2_sum_q;
        out_sum_d = out_sum_q;
        if (en) begin
            s1_vld_d  = in_valid;
            s2_vld_d  = s1_vld_q;
            out_vld_d = s2_vld_q;
            s1_id_d   = in_id;
            s2_id_d   = s1_id_q;
            out_id_d  = s2_id_q;
            // Each level widens by one bit, so no sum can overflow.
            for (int k = 0; k < NOPS/2; k++)
                s1_sum_d[k] = {1'b0, in_ops[2*k*W +: W]} + {1'b0, in_ops[(2*k+1)*W +: W]};
            for (int k = 0; k < NOPS/4; k++)
                s2_sum_d[k] = {1'b0, s1_sum_q[2*k]} + {1'b0, s1_sum_q[2*k+1]};
            out_sum_d = {1'b0, s2_sum_q[0]} + {1'b0, s2_sum_q[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            s1_id_q   <= '0;
            s2_id_q   <= '0;
            out_id_q  <= '0;
            out_sum_q <= '0;
            for (int k = 0; k < NOPS/2; k++) s1_sum_q[k] <= '0;
            for (int k = 0; k < NOPS/4; k++) s2_sum_q[k] <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            out_vld_q <= out_vld_d;
            s1_id_q   <= s1_id_d;
            s2_id_q   <= s2_id_d;
            out_id_q  <= out_id_d;
            out_sum_q <= out_sum_d;
            s1_sum_q  <= s1_sum_d;
            s2_sum_q  <= s2_sum_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_id    = out_id_q;
    assign out_sum   = out_sum_q;
endmodule

// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one adder tree among NREQ requesters; 3-cycle latency.
// The whole pipeline stalls while a result waits on out_ready; req_ready drops meanwhile.
module adder_tree_sched
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH = ADDER_WIDTH_DFLT,
    parameter int NREQ        = 4
) (
    input logic               clk,
    input logic               rst,
    adder_tree_sched_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int OPW = NOPS * ADDER_WIDTH;

    logic [MAX_REQ-1:0] vld_pad;
    logic [REQ_IDW-1:0] ptr_pad;
    pick_t              pick;
    logic [IDW-1:0]     grant_id;
    logic [NREQ-1:0]    ready;
    logic               advance, take;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic               s0_vld_q, s0_vld_d;
    logic [IDW-1:0]     s0_id_q, s0_id_d;
    logic [OPW-1:0]     s0_ops_q, s0_ops_d;
    logic [1:0]         inflight_q, inflight_d;
    logic               pipe_vld;

    always_comb begin
        vld_pad            = '0;
        vld_pad[NREQ-1:0]  = bus.req_valid;
        ptr_pad            = '0;
        ptr_pad[IDW-1:0]   = ptr_q;
    end

    assign pick     = rr_pick(vld_pad, ptr_pad, NREQ);
    assign grant_id = pick.idx[IDW-1:0];
    assign advance  = !pipe_vld || bus.out_ready;

    always_comb begin
        ready = '0;
        for (int i = 0; i < NREQ; i++)
            ready[i] = advance && pick.found && !rst && (pick.idx == REQ_IDW'(i));
    end

    assign take          = |ready;
    assign bus.req_ready = ready;

    always_comb begin
        ptr_d    = ptr_q;
        s0_vld_d = s0_vld_q;
        s0_id_d  = s0_id_q;
        s0_ops_d = s0_ops_q;
        if (take)
            ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
        if (advance) begin
            s0_vld_d = take;
            if (take) begin
                s0_id_d  = grant_id;
                s0_ops_d = bus.req_data[int'(grant_id)*OPW +: OPW];
            end
        end
    end

    // On an advance the s1..out window gains s0's bundle and loses the out bundle.
    always_comb begin
        inflight_d = inflight_q;
        if (advance && s0_vld_q && !pipe_vld)
            inflight_d = inflight_q + 2'd1;
        else if (advance && !s0_vld_q && pipe_vld)
            inflight_d = inflight_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s0_vld_q   <= 1'b0;
            s0_id_q    <= '0;
            s0_ops_q   <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s0_vld_q   <= s0_vld_d;
            s0_id_q    <= s0_id_d;
            s0_ops_q   <= s0_ops_d;
            inflight_q <= inflight_d;
        end
    end

    adder_tree_pipe #(
        .W   (ADDER_WIDTH),
        .IDW (IDW)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (advance),
        .in_valid  (s0_vld_q),
        .in_id     (s0_id_q),
        .in_ops    (s0_ops_q),
        .out_valid (pipe_vld),
        .out_id    (bus.out_id),
        .out_sum   (bus.out_data)
    );

    assign bus.out_valid = pipe_vld;
    assign bus.inflight  = inflight_q;
endmodule

// File: tb/tb_adder_tree_sched.sv
// Scoreboard bench for adder_tree_sched: directed vectors plus a random soak.
module tb_adder_tree_sched;
    localparam int W   = 48;
    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W+2:0]   sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t         sb[$];
    int           grant_log[$];
    logic [W+2:0] out_log[$];
    int           waits [N];
    exp_t         mon_e;
    logic         hold_vld = 1'b0;
    logic [W+2:0] hold_data;
    logic [IDW-1:0] hold_id;

    adder_tree_sched_if #(.ADDER_WIDTH(W), .NREQ(N)) bus ();

    adder_tree_sched #(.ADDER_WIDTH(W), .NREQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W+2:0] bundle_sum(input int i);
        logic [W+2:0] s;
        s = '0;
        for (int j = 0; j < 8; j++)
            s = s + {3'b000, bus.req_data[(i*8+j)*W +: W]};
        return s;
    endfunction

    task automatic set_op(input int i, input int j, input logic [W-1:0] v);
        bus.req_data[(i*8+j)*W +: W] = v;
    endtask

    task automatic set_all(input int i, input logic [W-1:0] v);
        for (int j = 0; j < 8; j++) set_op(i, j, v);
    endtask

    task automatic wait_grant(input int i, output bit got);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (bus.req_ready[i]) got = 1'b1;
        end
        check("grant_timeout", 64'(got), 64'd1);
    endtask

    task automatic single_shot(input int id, input logic [W+2:0] exp_sum);
        bit got;
        bus.req_valid[id] = 1'b1;
        wait_grant(id, got);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lat_early_valid", 64'(bus.out_valid), 64'd0);
        end
        @(negedge clk);
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("lat_sum", 64'(bus.out_data), 64'(exp_sum));
        check("lat_id", 64'(bus.out_id), 64'(id));
        check("lat_inflight", 64'(bus.inflight), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: records grants into the scoreboard, checks every output handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_vld = 1'b0;
            for (int i = 0; i < N; i++) waits[i] = 0;
        end else begin
            if (|bus.req_ready)
                check("ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i]) begin
                    check("ready_needs_valid", 64'(bus.req_valid[i]), 64'd1);
                    check("rr_wait_bound", 64'(waits[i] <= N-1), 64'd1);
                    mon_e.id  = IDW'(i);
                    mon_e.sum = bundle_sum(i);
                    sb.push_back(mon_e);
                    grant_log.push_back(i);
                    waits[i] = 0;
                end else if (bus.req_valid[i] && |bus.req_ready) begin
                    waits[i] = waits[i] + 1;
                end else if (!bus.req_valid[i]) begin
                    waits[i] = 0;
                end
            end
            if (hold_vld) begin
                check("stall_valid_held", 64'(bus.out_valid), 64'd1);
                check("stall_data_stable", 64'(bus.out_data), 64'(hold_data));
                check("stall_id_stable", 64'(bus.out_id), 64'(hold_id));
            end
            if (bus.out_valid && !bus.out_ready)
                check("stall_req_ready", 64'(bus.req_ready), 64'd0);
            hold_vld  = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            hold_id   = bus.out_id;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(sb.size()), 64'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_sum", 64'(bus.out_data), 64'(mon_e.sum));
                    check("sb_id", 64'(bus.out_id), 64'(mon_e.id));
                end
                out_log.push_back(bus.out_data);
            end
        end
    end

    initial begin
        bit              got;
        logic [N-1:0]    pend;
        logic [N-1:0]    took;

        // Reset: outputs zero and no ready even with every requester valid.
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_id", 64'(bus.out_id), 64'd0);
        check("rst_inflight", 64'(bus.inflight), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;

        // Single request, operands 1..8.
        for (int j = 0; j < 8; j++) set_op(2, j, W'(j + 1));
        single_shot(2, 51'd36);
        idle(4);

        // All-ones operands: full-precision sum without wrap.
        set_all(1, '1);
        single_shot(1, 51'h7_FFFF_FFFF_FFF8);
        idle(4);

        // Fairness from reset: grants 0,1,2,3,... one per cycle.
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_all(i, W'(10 * (i + 1)));
        bus.req_valid = '1;
        @(posedge clk); #1;
        grant_log.delete();
        out_log.delete();
        rst = 1'b0;
        idle(12);
        bus.req_valid = '0;
        check("fair_grant_count", 64'(grant_log.size()), 64'd12);
        for (int k = 0; k < 12 && k < grant_log.size(); k++)
            check("fair_grant_order", 64'(grant_log[k]), 64'(k % 4));
        idle(6);
        check("fair_out_count", 64'(out_log.size()), 64'd12);
        for (int k = 0; k < 8 && k < out_log.size(); k++)
            check("fair_out_sum", 64'(out_log[k]), 64'(80 * (k % 4 + 1)));
        idle(2);

        // Backpressure: six bundles from requester 3, five-cycle stall after the first result.
        out_log.delete();
        fork
            begin
                bit g;
                for (int b = 0; b < 6; b++) begin
                    set_all(3, W'(b + 1));
                    bus.req_valid[3] = 1'b1;
                    wait_grant(3, g);
                    @(posedge clk); #1;
                end
                bus.req_valid[3] = 1'b0;
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int c = 0; c < 30 && !seen; c++) begin
                    @(negedge clk);
                    if (bus.out_valid) seen = 1'b1;
                end
                check("bp_first_out", 64'(seen), 64'd1);
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("bp_inflight", 64'(bus.inflight), 64'd3);
                    check("bp_hold_sum", 64'(bus.out_data), 64'd16);
                    check("bp_hold_id", 64'(bus.out_id), 64'd3);
                    check("bp_req_ready", 64'(bus.req_ready), 64'd0);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        idle(10);
        check("bp_out_count", 64'(out_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < out_log.size(); k++)
            check("bp_out_sum", 64'(out_log[k]), 64'(8 * (k + 1)));

        // Mid-stream reset with three bundles inside the pipeline.
        for (int b = 0; b < 3; b++) begin
            set_all(0, W'(100 + b));
            bus.req_valid[0] = 1'b1;
            wait_grant(0, got);
            @(posedge clk); #1;
        end
        bus.req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
            check("mrst_inflight", 64'(bus.inflight), 64'd0);
        end
        idle(1);

        // Random soak: requesters hold valid and data until taken.
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            took = bus.req_ready & bus.req_valid;
            @(posedge clk); #1;
            pend = pend & ~took;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    for (int j = 0; j < 8; j++)
                        set_op(i, j, ($urandom_range(0, 7) == 0) ? '1 : W'({$urandom(), $urandom()}));
                end
            end
            bus.req_valid = pend;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 60 && pend != '0; c++) begin
            @(negedge clk);
            took = bus.req_ready & bus.req_valid;
            @(posedge clk); #1;
            pend          = pend & ~took;
            bus.req_valid = pend;
            bus.out_ready = 1'b1;
        end
        check("rand_pending_done", 64'(pend), 64'd0);
        idle(10);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
